// File: rtl/conversor_exibicao_bcd.sv
// Display stage: sequential double-dabble BCD conversion, 4-digit 7-segment drive, "Err" on ALU error.
// Optional macro SINAL_COMPLEMENTO_EN: two's-complement input with '-' on hex3; otherwise unsigned 0..255.
module conversor_exibicao_bcd #(
  parameter bit SEG_ATIVO_BAIXO = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] valor,
  input  logic       erro,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       ocupado,
  output logic       pronto
);

  typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA} estado_t;

  localparam logic [6:0] SEG_E       = 7'h06;
  localparam logic [6:0] SEG_R       = 7'h2F;
  localparam logic [6:0] SEG_MENOS   = 7'h3F;
  localparam logic [6:0] SEG_APAGADO = 7'h7F;

  function automatic logic [6:0] polaridade(input logic [6:0] codigo);
    return SEG_ATIVO_BAIXO ? codigo : ~codigo;
  endfunction

  function automatic logic [6:0] seg_digito(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = SEG_APAGADO;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: BCD field is sr[19:8], binary field sr[7:0].
  function automatic logic [19:0] passo_dd(input logic [19:0] sr);
    logic [19:0] t;
    t = sr;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  estado_t     estado_q, estado_d;
  logic [19:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  valor_q, valor_d;
  logic        erro_q, erro_d;
  logic        forca_q, forca_d;
  logic [6:0]  hex0_q, hex0_d;
  logic [6:0]  hex1_q, hex1_d;
  logic [6:0]  hex2_q, hex2_d;
  logic        pronto_q, pronto_d;
  logic [7:0]  magnitude;
  logic [3:0]  centena, dezena, unidade;

  assign centena = sr_q[19:16];
  assign dezena  = sr_q[15:12];
  assign unidade = sr_q[11:8];

`ifdef SINAL_COMPLEMENTO_EN
  logic       neg_q, neg_d;
  logic [6:0] hex3_q, hex3_d;

  // 8-bit negation of 0x80 yields 0x80, i.e. magnitude 128 unsigned.
  assign magnitude = valor[7] ? (~valor + 8'd1) : valor;
  assign hex3      = hex3_q;
`else
  assign magnitude = valor;
  assign hex3      = polaridade(SEG_APAGADO);
`endif

  always_comb begin
    estado_d = estado_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    valor_d  = valor_q;
    erro_d   = erro_q;
    forca_d  = forca_q;
    hex0_d   = hex0_q;
    hex1_d   = hex1_q;
    hex2_d   = hex2_q;
    pronto_d = 1'b0;
`ifdef SINAL_COMPLEMENTO_EN
    neg_d    = neg_q;
    hex3_d   = hex3_q;
`endif
    case (estado_q)
      OCIOSO: begin
        if (forca_q || ({erro, valor} != {erro_q, valor_q})) begin
          valor_d  = valor;
          erro_d   = erro;
          sr_d     = {12'b0, magnitude};
          cnt_d    = 4'd0;
          forca_d  = 1'b0;
          estado_d = CONVERTE;
`ifdef SINAL_COMPLEMENTO_EN
          neg_d    = valor[7];
`endif
        end
      end
      CONVERTE: begin
        sr_d  = passo_dd(sr_q);
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) estado_d = ATUALIZA;
      end
      ATUALIZA: begin
        pronto_d = 1'b1;
        estado_d = OCIOSO;
        if (erro_q) begin
          hex2_d = polaridade(SEG_E);
          hex1_d = polaridade(SEG_R);
          hex0_d = polaridade(SEG_R);
        end else begin
          hex2_d = polaridade((centena == 4'd0) ? SEG_APAGADO : seg_digito(centena));
          hex1_d = polaridade((centena == 4'd0 && dezena == 4'd0) ? SEG_APAGADO
                                                                   : seg_digito(dezena));
          hex0_d = polaridade(seg_digito(unidade));
        end
`ifdef SINAL_COMPLEMENTO_EN
        hex3_d = polaridade((neg_q && !erro_q) ? SEG_MENOS : SEG_APAGADO);
`endif
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      sr_q     <= '0;
      cnt_q    <= '0;
      valor_q  <= '0;
      erro_q   <= 1'b0;
      forca_q  <= 1'b1;
      hex0_q   <= polaridade(SEG_APAGADO);
      hex1_q   <= polaridade(SEG_APAGADO);
      hex2_q   <= polaridade(SEG_APAGADO);
      pronto_q <= 1'b0;
`ifdef SINAL_COMPLEMENTO_EN
      neg_q    <= 1'b0;
      hex3_q   <= polaridade(SEG_APAGADO);
`endif
    end else begin
      estado_q <= estado_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      valor_q  <= valor_d;
      erro_q   <= erro_d;
      forca_q  <= forca_d;
      hex0_q   <= hex0_d;
      hex1_q   <= hex1_d;
      hex2_q   <= hex2_d;
      pronto_q <= pronto_d;
`ifdef SINAL_COMPLEMENTO_EN
      neg_q    <= neg_d;
      hex3_q   <= hex3_d;
`endif
    end
  end

  assign hex0    = hex0_q;
  assign hex1    = hex1_q;
  assign hex2    = hex2_q;
  assign pronto  = pronto_q;
  assign ocupado = (estado_q != OCIOSO);

endmodule

// File: doc/conversor_exibicao_bcd.md
Name: conversor_exibicao_bcd

Overview:
- Display stage directly downstream of the RPN calculator top level.
- Consumes the 8-bit display value and the ALU error flag, and converts the value to BCD with a sequential double-dabble engine (one iteration per clock).
- Drives four 7-segment digits (HEX3..HEX0) with leading-zero blanking and shows "Err" when the error flag is set.
- Reconverts automatically whenever its inputs change.

Parameters:
- SEG_ATIVO_BAIXO, 1, 1 = segment outputs active-low (board displays); 0 = active-high (every segment bit inverted).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- valor  input  8  value to display (calculator display output)
- erro  input  1  ALU error flag; when high, display shows "Err"
- hex0  output  7  units digit, bit order {g,f,e,d,c,b,a}
- hex1  output  7  tens digit
- hex2  output  7  hundreds digit
- hex3  output  7  sign digit (used only with optional feature)
- ocupado  output  1  high while a conversion is in progress
- pronto  output  1  one-cycle pulse when new digits are registered

Behaviour:
- Reset (async, rst_n=0):
  - hex0..hex3 = blank (0x7F active-low); ocupado=0; pronto=0.
  - State = OCIOSO; last-value registers cleared; force flag set.
- Segment codes (active-low):
  - Digits 0..9 = 40,79,24,30,19,12,02,78,00,10 (hex).
  - E=06, r=2F, '-'=3F, blank=7F.
  - SEG_ATIVO_BAIXO=0 inverts all bits.
- FSM states: OCIOSO, CONVERTE, ATUALIZA.
- OCIOSO:
  - Start when {erro,valor} != last latched pair, or force flag is set.
  - On start: latch valor/erro, load shift register {12'b0, valor}, iteration counter=0, clear force flag, go to CONVERTE.
  - No start otherwise; outputs hold.
- CONVERTE:
  - Each cycle: add 3 to every BCD nibble >=5, then shift left 1; counter++.
  - After the 8th iteration, go to ATUALIZA.
- ATUALIZA:
  - Register digits, assert pronto for exactly one cycle, return to OCIOSO.
- Latency: input change sampled at edge E0; digits and pronto visible after edge E9 (10 edges total). ocupado high from E0 to E9 (9 cycles).
- Digit rules:
  - hex2 blank if hundreds=0.
  - hex1 blank if hundreds=0 and tens=0.
  - hex0 always shown.
  - Hundreds max 2.
- Error display: when latched erro=1, hex2/hex1/hex0 = E, r, r regardless of valor; hex3 blank.
- Input change during CONVERTE/ATUALIZA:
  - Ignored for the running conversion, which completes with the latched value.
  - Difference detected in the first OCIOSO cycle; new conversion starts there.
  - Back-to-back conversions are therefore separated by exactly 1 idle cycle.
- Reset mid-conversion: immediate return to reset values; force flag guarantees conversion of current inputs after release.
- Stable inputs: no conversions, pronto stays 0.

Optional Feature:
- Macro SINAL_COMPLEMENTO_EN.
- Defined:
  - valor is interpreted as two's complement.
  - If bit7=1, converted magnitude = -valor (0x80 gives 128); hex3='-' (3F).
  - Otherwise hex3 blank.
- Undefined:
  - valor is unsigned 0..255; hex3 permanently blank.
  - No sign logic synthesized.

Test Plan:
- Reset with valor=0, erro=0, then release -> within 11 cycles: hex0=40, hex1=hex2=hex3=7F; exactly one pronto pulse.
- valor changes to 255 -> 10 edges later: hex2=24, hex1=12, hex0=12; ocupado high 9 cycles; pronto 1 cycle.
- valor=105 -> hex2=79, hex1=40 (inner zero shown), hex0=12. valor=7 -> hex2=hex1=7F, hex0=78.
- erro=1 with valor=37 -> hex2/hex1/hex0 = 06, 2F, 2F. erro=0 -> hex1=30, hex0=78, hex2=7F.
- valor=12, then changed to 200 three cycles into the conversion -> first pronto shows 1,2; one idle cycle; second conversion; second pronto shows 24, 40, 40. rst_n pulsed mid-conversion -> outputs blank at once, correct digits after release.
- With SINAL_COMPLEMENTO_EN, valor=0x80 -> hex3=3F, hex2=79, hex1=24, hex0=00; valor=0xFF -> hex3=3F, hex0=79. Without the macro, valor=0x80 -> hex3=7F, digits 1, 2, 8.
